// File: rtl/sprite_bram_loader_pkg.sv
// Constants shared by the sprite BRAM loader and the read-side address generator:
// frame header, error codes, memory depth and region bases.
package sprite_bram_loader_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_FRAMING  = 3'd1;
    localparam logic [2:0] ERR_RANGE    = 3'd2;
    localparam logic [2:0] ERR_CHECKSUM = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    localparam int unsigned MEM_DEPTH = 11264;

    localparam logic [16:0] TILE_BASE = 17'd0;
    localparam logic [16:0] IDLE_BASE = 17'd1024;
    localparam logic [16:0] WALK_BASE = 17'd5120;

    typedef enum logic [3:0] {
        LD_IDLE, LD_A2, LD_A1, LD_A0, LD_C1, LD_C0, LD_PHI, LD_PLO, LD_CHK
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    // Widened so base + count can never wrap before the compare.
    function automatic logic span_fits(input logic [23:0] base,
                                       input logic [15:0] count,
                                       input int unsigned depth);
        logic [24:0] end_s;
        end_s = {1'b0, base} + {9'd0, count};
        return end_s <= 25'(depth);
    endfunction

endpackage

// File: rtl/sprite_bram_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, start bit re-checked at half a bit,
// data and stop bits sampled at mid-bit, LSB first.
module uart_rx #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);
    import sprite_bram_loader_pkg::*;

    localparam int unsigned BIT_CYC  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int          CNT_W    = $clog2(BIT_CYC + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    logic             rxd_meta_r;
    logic             rxd_sync_r;
    logic             rxd_prev_r;
    rx_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;

    // Synchronizer, bit timing and byte assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
            state_r    <= RX_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_data    <= 8'h00;
            rx_ferr    <= 1'b0;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
            rx_valid   <= 1'b0;
            rx_ferr    <= 1'b0;
            case (state_r)
                RX_IDLE: begin
                    if (rxd_prev_r && !rxd_sync_r) begin
                        state_r <= RX_START;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                RX_START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        bit_idx_r <= 3'd0;
                        state_r   <= rxd_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        shift_r <= {rxd_sync_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= RX_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= RX_IDLE;
                        if (rxd_sync_r) begin
                            rx_valid <= 1'b1;
                            rx_data  <= shift_r;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sprite_bram_loader.sv
// Receives framed RGB444 pixels over UART and writes them into BRAM port A,
// with range, checksum, framing and inter-byte timeout checks.
module sprite_bram_loader #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned MEM_DEPTH   = sprite_bram_loader_pkg::MEM_DEPTH,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rxd,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [11:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err_code
);
    import sprite_bram_loader_pkg::*;

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic             rx_valid_s;
    logic [7:0]       rx_data_s;
    logic             rx_ferr_s;
    logic [7:0]       chk_next_s;
    logic [23:0]      addr_full_s;
    logic [15:0]      count_full_s;
    logic             addr_bad_s;

    loader_state_t    state_r;
    logic [23:0]      addr_r;
    logic [15:0]      cnt_r;
    logic [3:0]       hi_r;
    logic [7:0]       chk_r;
    logic [TMO_W-1:0] tmo_r;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rxd      (uart_rxd),
        .rx_valid (rx_valid_s),
        .rx_data  (rx_data_s),
        .rx_ferr  (rx_ferr_s)
    );

    assign chk_next_s   = chk_r ^ rx_data_s;
    assign addr_full_s  = {addr_r[23:8], rx_data_s};
    assign count_full_s = {cnt_r[15:8], rx_data_s};
    assign addr_bad_s   = (addr_full_s >> ADDR_W) != 24'd0;

    // Frame parser, BRAM write port, status outputs and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= LD_IDLE;
            addr_r   <= 24'd0;
            cnt_r    <= 16'd0;
            hi_r     <= 4'd0;
            chk_r    <= 8'h00;
            tmo_r    <= {TMO_W{1'b0}};
            we       <= 1'b0;
            waddr    <= {ADDR_W{1'b0}};
            wdata    <= 12'h000;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            if (rx_valid_s) begin
                tmo_r <= {TMO_W{1'b0}};
                case (state_r)
                    LD_IDLE: begin
                        if (rx_data_s == HDR_BYTE) begin
                            err_code <= ERR_NONE;
                            chk_r    <= 8'h00;
                            busy     <= 1'b1;
                            state_r  <= LD_A2;
                        end
                    end
                    LD_A2: begin
                        addr_r[23:16] <= rx_data_s;
                        chk_r         <= chk_next_s;
                        state_r       <= LD_A1;
                    end
                    LD_A1: begin
                        addr_r[15:8] <= rx_data_s;
                        chk_r        <= chk_next_s;
                        state_r      <= LD_A0;
                    end
                    LD_A0: begin
                        if (addr_bad_s) begin
                            err_code <= ERR_RANGE;
                            busy     <= 1'b0;
                            state_r  <= LD_IDLE;
                        end else begin
                            addr_r[7:0] <= rx_data_s;
                            chk_r       <= chk_next_s;
                            state_r     <= LD_C1;
                        end
                    end
                    LD_C1: begin
                        cnt_r[15:8] <= rx_data_s;
                        chk_r       <= chk_next_s;
                        state_r     <= LD_C0;
                    end
                    LD_C0: begin
                        if (!span_fits(addr_r, count_full_s, MEM_DEPTH)) begin
                            err_code <= ERR_RANGE;
                            busy     <= 1'b0;
                            state_r  <= LD_IDLE;
                        end else begin
                            cnt_r   <= count_full_s;
                            chk_r   <= chk_next_s;
                            state_r <= (count_full_s == 16'd0) ? LD_CHK : LD_PHI;
                        end
                    end
                    LD_PHI: begin
                        hi_r    <= rx_data_s[3:0];
                        chk_r   <= chk_next_s;
                        state_r <= LD_PLO;
                    end
                    LD_PLO: begin
                        we      <= 1'b1;
                        waddr   <= addr_r[ADDR_W-1:0];
                        wdata   <= {hi_r, rx_data_s};
                        addr_r  <= addr_r + 24'd1;
                        cnt_r   <= cnt_r - 16'd1;
                        chk_r   <= chk_next_s;
                        state_r <= (cnt_r == 16'd1) ? LD_CHK : LD_PHI;
                    end
                    LD_CHK: begin
                        busy    <= 1'b0;
                        state_r <= LD_IDLE;
                        if (rx_data_s == chk_r) begin
                            done <= 1'b1;
                        end else begin
                            err_code <= ERR_CHECKSUM;
                        end
                    end
                    default: begin
                        busy    <= 1'b0;
                        state_r <= LD_IDLE;
                    end
                endcase
            end else if (rx_ferr_s && busy) begin
                err_code <= ERR_FRAMING;
                busy     <= 1'b0;
                state_r  <= LD_IDLE;
            end else if (busy && (tmo_r == TMO_LAST)) begin
                err_code <= ERR_TIMEOUT;
                busy     <= 1'b0;
                state_r  <= LD_IDLE;
                tmo_r    <= {TMO_W{1'b0}};
            end else if (busy) begin
                tmo_r <= tmo_r + 1'b1;
            end else begin
                tmo_r <= {TMO_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_sprite_bram_loader.sv
// Self-checking bench for sprite_bram_loader: directed frames plus random frames
// checked against a frame-level model of writes, done and err_code.
module tb_sprite_bram_loader;
    import sprite_bram_loader_pkg::*;

    localparam int unsigned BIT = 10;
    localparam int unsigned TMO = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rxd;
    logic        we;
    logic [16:0] waddr;
    logic [11:0] wdata;
    logic        busy;
    logic        done;
    logic [2:0]  err_code;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [16:0] wa_q[$];
    logic [11:0] wd_q[$];
    int          done_cnt    = 0;
    int          last_we_cyc = 0;
    logic [7:0]  hi_q[$];
    logic [7:0]  lo_q[$];

    sprite_bram_loader #(
        .CLK_HZ      (100000000),
        .BAUD        (10000000),
        .ADDR_W      (17),
        .MEM_DEPTH   (MEM_DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (uart_rxd),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
            last_we_cyc = cyc;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rxd = stop_bit;
        repeat (BIT) @(negedge clk);
        if (!stop_bit) begin
            uart_rxd = 1'b1;
            repeat (2 * BIT) @(negedge clk);
        end
    endtask

    task automatic fill(input int n);
        hi_q.delete();
        lo_q.delete();
        for (int i = 0; i < n; i++) begin
            hi_q.push_back(8'($urandom));
            lo_q.push_back(8'($urandom));
        end
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
    endtask

    // Builds a frame from hi_q/lo_q, predicts the outcome from the frame rules,
    // sends it (stopping at the byte that is expected to abort it) and checks.
    task automatic run_frame(input string tag, input logic [23:0] a, input bit corrupt);
        logic [7:0]  bytes[$];
        logic [7:0]  chk;
        logic [15:0] c;
        int n, nsend, exp_n, exp_err, exp_done;
        n = hi_q.size();
        c = 16'(n);
        bytes.push_back(a[23:16]);
        bytes.push_back(a[15:8]);
        bytes.push_back(a[7:0]);
        bytes.push_back(c[15:8]);
        bytes.push_back(c[7:0]);
        for (int i = 0; i < n; i++) begin
            bytes.push_back(hi_q[i]);
            bytes.push_back(lo_q[i]);
        end
        chk = 8'h00;
        foreach (bytes[i]) chk = chk ^ bytes[i];
        bytes.push_back(corrupt ? (chk ^ 8'h3C) : chk);

        if (int'(a) >= (1 << 17)) begin
            nsend = 3; exp_n = 0; exp_err = 2; exp_done = 0;
        end else if (int'(a) + n > int'(MEM_DEPTH)) begin
            nsend = 5; exp_n = 0; exp_err = 2; exp_done = 0;
        end else begin
            nsend = bytes.size(); exp_n = n;
            exp_err = corrupt ? 3 : 0;
            exp_done = corrupt ? 0 : 1;
        end

        clear_mon();
        send_byte(HDR_BYTE, 1'b1);
        for (int i = 0; i < nsend; i++) send_byte(bytes[i], 1'b1);
        repeat (4) @(negedge clk);

        check({tag, "_nwr"}, wa_q.size(), exp_n);
        for (int i = 0; i < exp_n && i < wa_q.size(); i++) begin
            check({tag, "_waddr"}, wa_q[i], 32'(int'(a) + i));
            check({tag, "_wdata"}, wd_q[i], {20'd0, hi_q[i][3:0], lo_q[i]});
        end
        check({tag, "_done"}, done_cnt, exp_done);
        check({tag, "_err"}, err_code, exp_err);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int target;
        int end_cyc;
        int nwr;
        logic [23:0] ra;

        rst = 1'b1;
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_code, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        hi_q = {8'h0F};
        lo_q = {8'h12};
        run_frame("single", 24'h000000, 1'b0);

        fill(2);
        run_frame("range_cnt", 24'h002BFF, 1'b0);
        fill(1);
        run_frame("fit_end", 24'h002BFF, 1'b0);
        fill(0);
        run_frame("zero_cnt", 24'(WALK_BASE), 1'b0);
        fill(1);
        run_frame("range_addr", 24'h020000, 1'b0);
        fill(3);
        run_frame("chk_bad", 24'(WALK_BASE), 1'b1);

        // Framing error on the C1 byte, then a clean frame.
        clear_mon();
        send_byte(HDR_BYTE, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        check("ferr_err", err_code, 1);
        check("ferr_busy", busy, 0);
        fill(2);
        run_frame("after_ferr", 24'h000410, 1'b0);

        // Timeout after a LO byte: exact timing from the observed write.
        clear_mon();
        send_byte(HDR_BYTE, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'h89, 1'b1);
        check("tmo_lo_nwr", wa_q.size(), 1);
        target = last_we_cyc + int'(TMO) - 1;
        while (cyc < target) @(negedge clk);
        check("tmo_lo_pre_err", err_code, 0);
        check("tmo_lo_pre_busy", busy, 1);
        @(negedge clk);
        check("tmo_lo_err", err_code, 4);
        check("tmo_lo_busy", busy, 0);

        // Timeout after a PHI byte.
        clear_mon();
        send_byte(HDR_BYTE, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h0A, 1'b1);
        end_cyc = cyc;
        while (cyc < end_cyc + int'(TMO) - int'(2 * BIT)) @(negedge clk);
        check("tmo_hi_pre_err", err_code, 0);
        check("tmo_hi_pre_busy", busy, 1);
        while (cyc < end_cyc + int'(TMO) + int'(BIT)) @(negedge clk);
        check("tmo_hi_err", err_code, 4);
        check("tmo_hi_busy", busy, 0);
        check("tmo_hi_nwr", wa_q.size(), 0);

        // Reset between pixel 2 and pixel 3 of a 4-pixel frame.
        clear_mon();
        send_byte(HDR_BYTE, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h0C, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'hBC, 1'b1);
        send_byte(8'h0D, 1'b1);
        send_byte(8'hEF, 1'b1);
        check("rstmid_nwr_pre", wa_q.size(), 2);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_we", we, 0);
        check("rstmid_waddr", waddr, 0);
        check("rstmid_wdata", wdata, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check("rstmid_err", err_code, 0);
        rst = 1'b0;
        @(negedge clk);
        nwr = wa_q.size();
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h77, 1'b1);
        repeat (4) @(negedge clk);
        check("rstmid_nwr_post", wa_q.size(), nwr);
        check("rstmid_busy_post", busy, 0);
        check("rstmid_done_post", done_cnt, 0);
        fill(3);
        run_frame("post_rst", 24'(IDLE_BASE), 1'b0);

        for (int k = 0; k < 10; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) ra = 24'h020000 | 24'($urandom_range(0, 65535));
            else if (r == 1) ra = 24'(MEM_DEPTH - $urandom_range(0, 3));
            else ra = 24'($urandom_range(0, MEM_DEPTH - 5));
            fill(int'($urandom_range(0, 4)));
            run_frame("rand", ra, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_bram_loader.md
# sprite_bram_loader

Write-side companion to the VGA sprite/tile address generator. It receives framed RGB444 pixel data over a UART link and writes it into port A of the shared sprite/tile BRAM, so the tile and sprite images can be replaced at run time. Port B stays with the 25 MHz read path. This block runs on the system clock and owns only the write port.

## Interface
- CLK_HZ, 100000000, system clock frequency.
- BAUD, 115200, UART bit rate (8N1).
- ADDR_W, 17, BRAM address width.
- MEM_DEPTH, 11264, number of valid BRAM words. Layout: tiles at 0, idle strip at 1024, walk strip at 5120.
- TIMEOUT_CYC, 1000000, maximum idle clk cycles between bytes inside a frame.
- Ports:
  - clk  in  1  system clock.
  - rst  in  1  reset, asynchronous, active-high.
  - uart_rxd  in  1  serial input; idle high; asynchronous to clk.
  - we  out  1  BRAM write enable, one-cycle pulse per pixel.
  - waddr  out  ADDR_W  BRAM write address.
  - wdata  out  12  pixel, {R[3:0], G[3:0], B[3:0]}.
  - busy  out  1  high from header accept until the frame ends (done, error, or reset).
  - done  out  1  one-cycle pulse when a frame completes with a good checksum.
  - err_code  out  3  0 none, 1 framing, 2 range, 3 checksum, 4 timeout. Holds until the next header byte is accepted.

## Operation
- Frame format: 0xA5, ADDR[23:16], ADDR[15:8], ADDR[7:0], CNT[15:8], CNT[7:0], then CNT pixel pairs (HI, LO), then CHK.
  - A pixel is {HI[3:0], LO[7:0]}. HI[7:4] is ignored.
  - CHK is the XOR of every byte after 0xA5 up to the last pixel byte.
- UART RX:
  - uart_rxd passes through a 2-FF synchronizer.
  - Start bit: a falling edge, re-checked at half a bit time.
  - Data bits are sampled at mid-bit, LSB first. Bit period = round(CLK_HZ/BAUD) = 868 at the defaults.
  - The stop bit is sampled at mid-bit. A 0 there flags a framing error and emits no byte.
  - A good byte produces rx_valid for one cycle with rx_data.
- Loader FSM states: IDLE, A2, A1, A0, C1, C0, PHI, PLO, CHK.
  - IDLE: discard bytes other than 0xA5. On 0xA5: clear err_code and the checksum accumulator, set busy, go to A2.
  - A2, A1, A0: load the address big-endian. At A0, if ADDR[23:17] ≠ 0, raise error 2.
  - C1, C0: load the count. At C0, if ADDR+CNT > MEM_DEPTH (17+16 bit compare, no overflow), raise error 2. Otherwise go to CHK if CNT = 0, else to PHI.
  - PHI: latch HI[3:0].
  - PLO: issue the write. waddr = current address, wdata = {hi, LO}, we = 1. Then increment the address and decrement the remaining count. Go to CHK if remaining reaches 0, else to PHI.
  - CHK: match → done, busy low, IDLE. Mismatch → error 3.
- Any error: set err_code, drop busy, return to IDLE. Pixels already written are not rolled back.
- A framing error while busy gives error 1. A framing error in IDLE is ignored.
- Timeout: while busy, a counter is cleared on every rx_valid. Reaching TIMEOUT_CYC gives error 4.
- A 0xA5 byte inside a frame is treated as data. There is no mid-frame resync.

## Timing
- Reset values: we = 0, waddr = 0, wdata = 0, busy = 0, done = 0, err_code = 0; FSM in IDLE; UART RX idle.
- An asynchronous reset mid-frame aborts at once. No write is issued after rst rises.
- we, waddr and wdata are registered and valid together in the cycle after the rx_valid of the LO byte. waddr and wdata hold their values between pulses.
- done, and the err_code update, occur in the cycle after the triggering rx_valid. Error 4 is set in the cycle the counter reaches TIMEOUT_CYC.
- busy rises in the cycle after the header's rx_valid.
- There is at most one write per 2 byte times, so the BRAM port needs no backpressure.
- Byte latency: about 9.5 bit times from the start-bit edge to rx_valid, plus 2 cycles of synchronizer delay.

## Structure
- Shared package holds: the header constant 0xA5, the err_code encodings, MEM_DEPTH and the region base addresses (0, 1024, 5120). The read-side address generator uses the same constants.
- Sub-module uart_rx, parameterized by CLK_HZ and BAUD. Outputs: rx_valid, rx_data[7:0], rx_ferr (one-cycle pulse).
- The loader FSM, checksum, address/count registers and timeout counter live in sprite_bram_loader.

## Test plan
- Single pixel: frame A5 00 00 00 00 01 0F 12 1C → one we pulse with waddr = 0, wdata = 0xF12, then done; err_code = 0.
- Range: start address 0x002BFF (11263) with CNT = 2 → err_code = 2 after the C0 byte, no we, busy low.
- Checksum: a valid 3-pixel frame with CHK corrupted → three writes at addresses N..N+2, then err_code = 3, no done.
- Framing: the C1 byte is sent with stop bit = 0 → err_code = 1, FSM in IDLE; the next correct frame completes with done.
- Timeout: the stream stops after a PHI byte → err_code = 4 exactly TIMEOUT_CYC cycles after the last rx_valid; busy low.
- Reset mid-stream: rst pulsed between pixel 2 and pixel 3 of a 4-pixel frame → all outputs 0 and no further we; a following frame to address 1024 writes correctly.
